// File: rtl/mainmem_pkg.sv
// Shared types and constants for the main-memory responder.
package mainmem_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DEFAULT_LATENCY = 4;
    localparam int unsigned LAT_CNT_W       = 4;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_READY} state_t;

endpackage

// File: rtl/memarray.sv
// Synchronous single-port word RAM with registered read; write-first so a write echoes its data.
module memarray
    import mainmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [WORD_W-1:0]     wd,
    output logic [WORD_W-1:0]     rd
);

    logic [WORD_W-1:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[idx] <= wd;
            rd       <= wd;
        end else begin
            rd <= mem[idx];
        end
    end

endmodule

// File: rtl/mainmemory.sv
// Word-addressed memory responder with programmable access latency.
// Define MAINMEM_FASTBURST_EN to serve back-to-back words of one 4-word block without latency.
module mainmemory
    import mainmem_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MReq,
    input  logic [31:0] MAddr,
    input  logic        MWE,
    input  logic [31:0] MWD,
    output logic        MReady,
    output logic [31:0] MRD,
    output logic        Busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(LATENCY - 1);

    state_t                state, state_next;
    logic [LAT_CNT_W-1:0]  cnt, cnt_next;
    logic                  access;
    logic                  fast_hit;
    logic [ADDR_WIDTH-1:0] idx;
    logic [WORD_W-1:0]     ram_rd;
    logic [WORD_W-1:0]     mrd_hold;
    logic                  unused_maddr;

    assign idx          = MAddr[ADDR_WIDTH+1:2];
    assign unused_maddr = ^{MAddr[31:ADDR_WIDTH+2], MAddr[1:0]};

`ifdef MAINMEM_FASTBURST_EN
    logic [27:0] tag;
    logic        tag_valid;
    logic        tag_we;

    assign fast_hit = tag_valid && (MAddr[31:4] == tag) && (MWE == tag_we);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            tag       <= '0;
            tag_valid <= 1'b0;
            tag_we    <= 1'b0;
        end else if (access) begin
            tag       <= MAddr[31:4];
            tag_valid <= 1'b1;
            tag_we    <= MWE;
        end else if (state == S_BUSY && !MReq) begin
            tag_valid <= 1'b0;
        end
    end
`else
    assign fast_hit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mrd_hold <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_READY) begin
                mrd_hold <= ram_rd;
            end
        end
    end

    // The RAM access (and the write commit) happens on the edge that enters READY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        access     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (MReq) begin
                    if (fast_hit) begin
                        state_next = S_READY;
                        access     = 1'b1;
                    end else begin
                        state_next = S_BUSY;
                        cnt_next   = LAT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (!MReq) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == '0) begin
                    state_next = S_READY;
                    access     = 1'b1;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_READY: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    memarray #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_memarray (
        .CLK(CLK),
        .we (access & MWE),
        .idx(idx),
        .wd (MWD),
        .rd (ram_rd)
    );

    assign MReady = (state == S_READY);
    assign Busy   = (state == S_BUSY);
    assign MRD    = (state == S_READY) ? ram_rd : mrd_hold;

endmodule
